pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the VPU front end; supersedes the bare PC adder.
//  Holds the PC register and sequences it: sequential increment, PC-relative branch, absolute jump.
//  Adds a zero-overhead hardware loop for vector strip-mining.
//  Presents each PC to instruction fetch over a valid/ready handshake.
// PARAMETERS
//  XLEN        32     PC / address width
//  INC         4      sequential increment in bytes; power of 2, >=1
//  RESET_PC    0      PC value loaded on reset (XLEN bits)
//  LOOP_CNT_W  16     width of the hardware-loop iteration counter
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  stall_i        in   1           pipeline stall; hold PC
//  branch_i       in   1           take PC-relative branch this cycle
//  branch_off_i   in   XLEN        two's-complement byte offset, added to pc_o
//  jump_i         in   1           take absolute jump this cycle
//  jump_tgt_i     in   XLEN        absolute jump target
//  loop_set_i     in   1           arm hardware loop
//  loop_start_i   in   XLEN        loop body first address
//  loop_end_i     in   XLEN        loop body last-instruction address
//  loop_cnt_i     in   LOOP_CNT_W  iteration count (0 = do not arm)
//  fetch_ready_i  in   1           fetch accepts pc_o this cycle
//  fetch_valid_o  out  1           pc_o is a valid fetch request
//  pc_o           out  XLEN        current PC (registered)
//  pc_next_o      out  XLEN        combinational next PC
//  loop_active_o  out  1           hardware loop armed
//  loop_cnt_o     out  LOOP_CNT_W  remaining iterations
//  misalign_o     out  1           1-cycle pulse: redirect target was not INC-aligned
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs go to their reset values immediately.
//  - State=BOOT, pc_o=RESET_PC, fetch_valid_o=0, loop_active_o=0, loop_cnt_o=0, misalign_o=0.
//  FSM states:
//  - BOOT: one cycle after rst_n rises, then -> RUN.
//  - RUN: fetch_valid_o=1.
//  - BUBBLE: fetch_valid_o=0 for one cycle after any redirect, then -> RUN.
//  Advance condition: adv = (state==RUN) & fetch_ready_i & ~stall_i.
//  Next-PC priority: jump_i > branch_i > loop-back > sequential > hold.
//  - jump_i:   pc <= jump_tgt_i; state -> BUBBLE. Overrides stall_i and an unaccepted request (flush).
//  - branch_i: pc <= pc_o + branch_off_i, modulo 2^XLEN; state -> BUBBLE. Overrides stall_i (flush).
//  - Redirects are also honoured in BOOT and in BUBBLE; each one restarts the BUBBLE cycle.
//  - loop-back: when adv & loop_active_o & pc_o==loop_end & loop_cnt_o>1, pc <= loop_start; cnt -= 1. No bubble.
//  - Loop exit: when adv & loop_active_o & pc_o==loop_end & loop_cnt_o==1:
//    pc <= pc_o+INC; cnt <= 0; loop_active_o <= 0.
//  - sequential: when adv and no other case applies, pc <= pc_o+INC (wraps at 2^XLEN).
//  - hold: otherwise pc holds. pc_o stays stable while fetch_valid_o=1 & fetch_ready_i=0.
//  Redirect alignment:
//  - Targets have their low log2(INC) bits cleared.
//  - If any cleared bit was 1, misalign_o=1 in the following cycle.
//  Loop arming:
//  - loop_set_i with loop_cnt_i!=0 captures start, end and count; loop_active_o=1 next cycle.
//  - Arming overwrites any loop already active.
//  - loop_cnt_i==0 is ignored.
//  - loop_set_i in the same cycle as a loop-back: arming wins, and the current loop-back still occurs.
//  - Redirects never modify loop state.
//  pc_next_o is the value pc will load at the next edge, with the priority above applied.
//  Latency: redirect to new pc_o is 1 cycle; redirect to fetch_valid_o=1 at the new PC is 2 cycles.
// TESTING
//  T1 reset: RESET_PC=0x100, fetch_ready_i=1.
//     -> pc_o=0x100, valid=0 in BOOT.
//     -> then 0x100, 0x104, 0x108 on consecutive cycles with valid=1.
//  T2 backpressure: fetch_ready_i=0 for 3 cycles at pc 0x108.
//     -> pc_o stays 0x108, valid=1; advances to 0x10C one cycle after ready returns.
//  T3 branch: pc 0x200, branch_off_i=-8.
//     -> pc_o=0x1F8 next cycle, valid=0 for one cycle, then 0x1F8 valid, then 0x1FC.
//  T4 jump vs branch: jump_i=branch_i=1 with stall_i=1, target 0x403.
//     -> pc_o=0x400, misalign_o pulses 1 cycle, BUBBLE.
//  T5 loop: arm start 0x20, end 0x28, cnt 3; run from 0x20.
//     -> fetch sequence 20,24,28 x3, then 0x2C; loop_cnt_o 3->2->1->0; loop_active_o drops.
//  T6 wrap/reset mid-op: pc 0xFFFFFFFC advances to 0x0.
//     -> assert rst_n=0 mid-loop: outputs reset immediately; loop cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential / branch / jump redirects, a zero-overhead
// hardware loop, and a valid/ready fetch request carrying the registered PC.
module pc_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     INC        = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     LOOP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic [XLEN-1:0]       branch_off_i,
  input  logic                  jump_i,
  input  logic [XLEN-1:0]       jump_tgt_i,
  input  logic                  loop_set_i,
  input  logic [XLEN-1:0]       loop_start_i,
  input  logic [XLEN-1:0]       loop_end_i,
  input  logic [LOOP_CNT_W-1:0] loop_cnt_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [XLEN-1:0]       pc_next_o,
  output logic                  loop_active_o,
  output logic [LOOP_CNT_W-1:0] loop_cnt_o,
  output logic                  misalign_o
);

  localparam logic [XLEN-1:0]       INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0]       ALIGN_MASK = XLEN'(INC - 1);
  localparam logic [LOOP_CNT_W-1:0] CNT_ONE    = LOOP_CNT_W'(1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_BUBBLE
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  misalign_q, misalign_d;
  logic                  loop_active_q, loop_active_d;
  logic [LOOP_CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [XLEN-1:0]       loop_start_q, loop_start_d;
  logic [XLEN-1:0]       loop_end_q, loop_end_d;

  logic                  adv;
  logic                  redirect;
  logic [XLEN-1:0]       redir_raw;
  logic [XLEN-1:0]       redir_tgt;
  logic                  loop_hit;
  logic                  loop_back;
  logic                  arm;

  always_comb begin
    adv       = (state_q == S_RUN) && fetch_ready_i && !stall_i;
    redirect  = jump_i || branch_i;
    redir_raw = jump_i ? jump_tgt_i : (pc_q + branch_off_i);
    redir_tgt = redir_raw & ~ALIGN_MASK;
    loop_hit  = adv && loop_active_q && (pc_q == loop_end_q);
    loop_back = loop_hit && (loop_cnt_q > CNT_ONE);
    arm       = loop_set_i && (loop_cnt_i != '0);

    pc_d = pc_q;
    if (redirect) begin
      pc_d = redir_tgt;
    end else if (loop_back) begin
      pc_d = loop_start_q;
    end else if (adv) begin
      pc_d = pc_q + INC_V;
    end

    state_d    = redirect ? S_BUBBLE : S_RUN;
    valid_d    = (state_d == S_RUN);
    misalign_d = redirect && ((redir_raw & ALIGN_MASK) != '0);

    // Arming takes the new loop, but this cycle's loop-back above still uses the old start.
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    loop_start_d  = loop_start_q;
    loop_end_d    = loop_end_q;
    if (arm) begin
      loop_active_d = 1'b1;
      loop_cnt_d    = loop_cnt_i;
      loop_start_d  = loop_start_i;
      loop_end_d    = loop_end_i;
    end else if (loop_hit && !redirect) begin
      if (loop_back) begin
        loop_cnt_d = loop_cnt_q - CNT_ONE;
      end else begin
        loop_cnt_d    = '0;
        loop_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      misalign_q    <= 1'b0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      loop_start_q  <= '0;
      loop_end_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      misalign_q    <= misalign_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_start_q  <= loop_start_d;
      loop_end_q    <= loop_end_d;
    end
  end

  assign fetch_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_next_o     = pc_d;
  assign loop_active_o = loop_active_q;
  assign loop_cnt_o    = loop_cnt_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a cycle model pushes expected outputs into a scoreboard
// queue as stimulus is applied; entries are popped and compared after each edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i, branch_i, jump_i, loop_set_i, fetch_ready_i;
  logic [31:0] branch_off_i, jump_tgt_i, loop_start_i, loop_end_i;
  logic [15:0] loop_cnt_i;
  logic        fetch_valid_o, loop_active_o, misalign_o;
  logic [31:0] pc_o, pc_next_o;
  logic [15:0] loop_cnt_o;

  pc_sequencer #(
    .XLEN      (32),
    .INC       (4),
    .RESET_PC  (32'h100),
    .LOOP_CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .branch_off_i (branch_off_i),
    .jump_i       (jump_i),
    .jump_tgt_i   (jump_tgt_i),
    .loop_set_i   (loop_set_i),
    .loop_start_i (loop_start_i),
    .loop_end_i   (loop_end_i),
    .loop_cnt_i   (loop_cnt_i),
    .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o),
    .pc_o         (pc_o),
    .pc_next_o    (pc_next_o),
    .loop_active_o(loop_active_o),
    .loop_cnt_o   (loop_cnt_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        la;
    logic [15:0] cnt;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state: 0 boot, 1 run, 2 bubble
  int          m_st;
  logic [31:0] m_pc, m_ls, m_le;
  logic        m_la;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    stall_i = 0; branch_i = 0; jump_i = 0; loop_set_i = 0;
    branch_off_i = '0; jump_tgt_i = '0; loop_start_i = '0; loop_end_i = '0;
    loop_cnt_i = '0; fetch_ready_i = 1;
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 32'h100; m_la = 0; m_cnt = '0; m_ls = '0; m_le = '0;
  endtask

  // Inputs are already driven (at a negedge); predict, push, clock, pop, compare.
  task automatic cycle();
    exp_t        e;
    logic [31:0] raw, npc;
    bit          adv, hit, redir;
    #1;
    adv   = (m_st == 1) && fetch_ready_i && !stall_i;
    redir = jump_i || branch_i;
    raw   = jump_i ? jump_tgt_i : m_pc + branch_off_i;
    hit   = adv && m_la && (m_pc == m_le);
    if (redir)                  npc = {raw[31:2], 2'b00};
    else if (hit && m_cnt > 1)  npc = m_ls;
    else if (adv)               npc = m_pc + 32'd4;
    else                        npc = m_pc;
    check("pc_next", pc_next_o, npc);
    if (loop_set_i && loop_cnt_i != 0) begin
      m_la = 1; m_cnt = loop_cnt_i; m_ls = loop_start_i; m_le = loop_end_i;
    end else if (hit && !redir) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin m_cnt = 0; m_la = 0; end
    end
    m_st    = redir ? 2 : 1;
    m_pc    = npc;
    e.pc    = npc;
    e.valid = (m_st == 1);
    e.la    = m_la;
    e.cnt   = m_cnt;
    e.mis   = redir && (raw[1:0] != 2'b00);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("pc", pc_o, e.pc);
      check("valid", fetch_valid_o, e.valid);
      check("loop_active", loop_active_o, e.la);
      check("loop_cnt", loop_cnt_o, e.cnt);
      check("misalign", misalign_o, e.mis);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 0;
    #1;
    check("rst_pc", pc_o, 32'h100);
    check("rst_valid", fetch_valid_o, 1'b0);
    check("rst_la", loop_active_o, 1'b0);
    check("rst_cnt", loop_cnt_o, 16'd0);
    check("rst_mis", misalign_o, 1'b0);
    model_reset();
    sb.delete();
    @(negedge clk);
    clr();
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    model_reset();
    @(negedge clk);
    apply_reset();

    // T1: boot then sequential fetch
    cycle();
    check("t1_boot_pc", pc_o, 32'h100);
    cycle(); cycle();
    check("t1_pc", pc_o, 32'h108);

    // T2: backpressure holds the PC
    repeat (3) begin fetch_ready_i = 0; cycle(); end
    check("t2_hold_pc", pc_o, 32'h108);
    check("t2_hold_valid", fetch_valid_o, 1'b1);
    cycle();
    check("t2_adv_pc", pc_o, 32'h10C);

    // T3: branch backwards
    jump_i = 1; jump_tgt_i = 32'h200; cycle();
    cycle();
    branch_i = 1; branch_off_i = -32'sd8; cycle();
    check("t3_br_pc", pc_o, 32'h1F8);
    check("t3_br_valid", fetch_valid_o, 1'b0);
    cycle(); cycle();
    check("t3_seq_pc", pc_o, 32'h1FC);

    // T4: jump beats branch and stall; misaligned target
    jump_i = 1; branch_i = 1; stall_i = 1; jump_tgt_i = 32'h403; branch_off_i = 32'h40;
    cycle();
    check("t4_pc", pc_o, 32'h400);
    check("t4_mis", misalign_o, 1'b1);
    cycle();
    check("t4_mis_pulse", misalign_o, 1'b0);

    // T5: three-iteration loop; a zero-count arm is ignored
    jump_i = 1; jump_tgt_i = 32'h20;
    loop_set_i = 1; loop_start_i = 32'h20; loop_end_i = 32'h28; loop_cnt_i = 16'd3;
    cycle();
    loop_set_i = 1; loop_start_i = 32'h80; loop_end_i = 32'h80; loop_cnt_i = 16'd0;
    cycle();
    repeat (9) cycle();
    check("t5_exit_pc", pc_o, 32'h2C);
    check("t5_exit_la", loop_active_o, 1'b0);

    // re-arm coinciding with a loop-back
    jump_i = 1; jump_tgt_i = 32'h60;
    loop_set_i = 1; loop_start_i = 32'h60; loop_end_i = 32'h64; loop_cnt_i = 16'd2;
    cycle();
    cycle(); cycle();
    loop_set_i = 1; loop_start_i = 32'h90; loop_end_i = 32'h94; loop_cnt_i = 16'd7;
    cycle();
    check("rearm_pc", pc_o, 32'h60);
    check("rearm_cnt", loop_cnt_o, 16'd7);

    // T6: wrap around 2^32, then reset mid-loop
    jump_i = 1; jump_tgt_i = 32'hFFFF_FFF8; cycle();
    cycle(); cycle(); cycle();
    check("t6_wrap", pc_o, 32'h0);
    jump_i = 1; jump_tgt_i = 32'h40;
    loop_set_i = 1; loop_start_i = 32'h40; loop_end_i = 32'h48; loop_cnt_i = 16'd5;
    cycle();
    repeat (4) cycle();
    apply_reset();
    cycle(); cycle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      fetch_ready_i = ($urandom % 4) != 0;
      stall_i       = ($urandom % 6) == 0;
      jump_i        = ($urandom % 25) == 0;
      branch_i      = ($urandom % 25) == 0;
      jump_tgt_i    = 32'h1000 + ($urandom % 64);
      branch_off_i  = 32'($urandom_range(0, 64)) - 32'd32;
      loop_set_i    = ($urandom % 12) == 0;
      loop_start_i  = 32'h1000 + 32'(4 * $urandom_range(0, 8));
      loop_end_i    = loop_start_i + 32'(4 * $urandom_range(0, 3));
      loop_cnt_i    = 16'($urandom_range(0, 3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
